// File: rtl/micro_op_sequencer.sv
// Micro-op sequencer: expands accepted macro ops into the decoder's 5-bit micro-op stream.
// LOAD -> LW_1,LW_2,LW_3; STORE -> SW_1,SW_2; other legal ops pass through in one cycle.
// Optional feature macro: SEQ_PERF_CNT_EN adds perf_issued / perf_stall counters.
module micro_op_sequencer #(
  parameter int unsigned OP_W    = 5,
  parameter int unsigned FIELD_W = 27
`ifdef SEQ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [FIELD_W-1:0] in_fields,
  input  logic               stall,
  input  logic               flush,
  output logic [OP_W-1:0]    opcode_out,
  output logic [FIELD_W-1:0] fields_out,
  output logic               out_valid,
  output logic               out_last,
  output logic               illegal
`ifdef SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_issued
  , output logic [CNT_W-1:0] perf_stall
`endif
);

  localparam logic [OP_W-1:0] OpLw1 = 5'b00000;
  localparam logic [OP_W-1:0] OpLw2 = 5'b00001;
  localparam logic [OP_W-1:0] OpLw3 = 5'b00010;
  localparam logic [OP_W-1:0] OpSw1 = 5'b00011;
  localparam logic [OP_W-1:0] OpSw2 = 5'b00100;
  localparam logic [OP_W-1:0] OpNop = 5'b10101;

  // State names the next micro-op to emit.
  typedef enum logic [1:0] {StIdle, StLw2, StLw3, StSw2} state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [FIELD_W-1:0] fields_q, fields_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               illegal_q, illegal_d;
  logic               accept;
  logic               in_illegal;

  assign in_ready = rst_n && (state_q == StIdle) && !stall && !flush;
  assign accept   = in_valid && in_ready;

  // Micro-only codes and anything above NOP are not valid macro ops.
  assign in_illegal = (in_op == OpLw2) || (in_op == OpLw3) || (in_op == OpSw2) ||
                      (in_op > OpNop);

  // Next-state and next-output selection; flush beats stall beats normal flow.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fields_d  = fields_q;
    valid_d   = valid_q;
    last_d    = last_q;
    illegal_d = 1'b0;
    if (flush) begin
      state_d = StIdle;
      op_d    = OpNop;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StIdle: begin
          op_d    = OpNop;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (accept) begin
            fields_d = in_fields;
            if (in_illegal) begin
              illegal_d = 1'b1;
            end else if (in_op == OpLw1) begin
              op_d    = OpLw1;
              valid_d = 1'b1;
              state_d = StLw2;
            end else if (in_op == OpSw1) begin
              op_d    = OpSw1;
              valid_d = 1'b1;
              state_d = StSw2;
            end else begin
              op_d    = in_op;
              valid_d = 1'b1;
              last_d  = 1'b1;
            end
          end
        end
        StLw2: begin
          op_d    = OpLw2;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = StLw3;
        end
        StLw3: begin
          op_d    = OpLw3;
          valid_d = 1'b1;
          last_d  = 1'b1;
          state_d = StIdle;
        end
        StSw2: begin
          op_d    = OpSw2;
          valid_d = 1'b1;
          last_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      fields_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fields_q  <= fields_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
    end
  end

  assign opcode_out = op_q;
  assign fields_out = fields_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign illegal    = illegal_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] issued_q, stall_cnt_q;

  // Issued counts fresh valid content; stall counts unflushed stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!flush && !stall && valid_d) issued_q <= issued_q + CNT_W'(1);
      if (stall && !flush) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_cnt_q;
`endif

endmodule
